// File: rtl/izh_synapse.sv
// rtl/izh_synapse.sv - current-based synapse feeding the Izhikevich neuron current input
module izh_synapse #(
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned DECAY_DIV   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        spike_in,
  input  logic [7:0]  weight,
  output logic [15:0] current,
  output logic        active,
  output logic [7:0]  event_count
);

  localparam int unsigned CW = $clog2(DECAY_DIV) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0]            cur_q, cur_d;
  logic                   act_q, act_d;
  logic [7:0]             evt_q, evt_d;

  logic        edge_det;
  logic        tick;
  logic [15:0] dec;
  logic [15:0] c1;
  logic [16:0] sum;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], spike_in};
    hist_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
    tick     = (cnt_q == CW'(DECAY_DIV - 1));
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    evt_d    = evt_q;
    dec      = cur_q >> DECAY_SHIFT;
    c1       = cur_q;
    sum      = '0;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        // Force a minimum step so small currents reach exactly zero.
        if ((cur_q != 16'd0) && (dec == 16'd0)) begin
          dec = 16'd1;
        end
        c1 = cur_q - dec;
      end
      if (edge_det) begin
        sum   = {1'b0, c1} + {9'd0, weight};
        cur_d = sum[16] ? 16'hFFFF : sum[15:0];
        evt_d = evt_q + 8'd1;
      end else begin
        cur_d = c1;
      end
    end
    act_d = (cur_d != 16'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      cur_q  <= '0;
      act_q  <= 1'b0;
      evt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      act_q  <= act_d;
      evt_q  <= evt_d;
    end
  end

  assign current     = cur_q;
  assign active      = act_q;
  assign event_count = evt_q;

endmodule

// File: tb/tb_izh_synapse.sv
// tb/tb_izh_synapse.sv - directed self-checking bench for izh_synapse
module tb_izh_synapse;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b1;
  logic        spike_in = 1'b0;
  logic [7:0]  weight = 8'd0;
  logic [15:0] cur_s, cur_f;
  logic        act_s, act_f;
  logic [7:0]  ec_s, ec_f;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Slow instance never ticks inside a test window; fast one ticks every 4 cycles.
  izh_synapse #(.DECAY_SHIFT(3), .DECAY_DIV(1000), .SYNC_STAGES(2)) u_slow (
    .clk(clk), .reset_n(reset_n), .en(en), .spike_in(spike_in), .weight(weight),
    .current(cur_s), .active(act_s), .event_count(ec_s)
  );

  izh_synapse #(.DECAY_SHIFT(3), .DECAY_DIV(4), .SYNC_STAGES(2)) u_fast (
    .clk(clk), .reset_n(reset_n), .en(en), .spike_in(spike_in), .weight(weight),
    .current(cur_f), .active(act_f), .event_count(ec_f)
  );

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic to_neg(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    spike_in = 1'b0;
    weight   = 8'd0;
    en       = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One-cycle pulse whose weight lands in current at posedge e.
  task automatic pulse_at(input int e, input logic [7:0] w);
    to_neg(e - 3);
    spike_in = 1'b1;
    to_neg(e - 2);
    spike_in = 1'b0;
    to_neg(e - 1);
    weight = w;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cur_s !== 16'd0 || cur_f !== 16'd0) begin fails++; $display("FAIL reset_init_current got=%0d/%0d exp=0", cur_s, cur_f); end
    checks++; if (act_s !== 1'b0 || ec_s !== 8'd0) begin fails++; $display("FAIL reset_init_flags active=%0b count=%0d exp=0/0", act_s, ec_s); end
    for (int i = 0; i < 19; i++) pulse_at(5 + 2 * i, (i < 18) ? 8'd255 : 8'd70);
    to_neg(41);
    checks++; if (cur_s !== 16'h1234) begin fails++; $display("FAIL reset_preload got=%h exp=1234", cur_s); end
    checks++; if (ec_s !== 8'd19 || act_s !== 1'b1) begin fails++; $display("FAIL reset_preload_flags count=%0d active=%0b exp=19/1", ec_s, act_s); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cur_s !== 16'd0 || act_s !== 1'b0 || ec_s !== 8'd0) begin fails++; $display("FAIL reset_async got=%0d/%0b/%0d exp=0/0/0", cur_s, act_s, ec_s); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (cur_s !== 16'd0 || act_s !== 1'b0 || ec_s !== 8'd0) begin fails++; $display("FAIL reset_hold cycle=%0d got=%0d/%0b/%0d exp=0/0/0", i, cur_s, act_s, ec_s); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    weight = 8'd100;
    to_neg(2);
    spike_in = 1'b1;
    to_neg(4);
    checks++; if (cur_s !== 16'd0) begin fails++; $display("FAIL latency_early got=%0d exp=0", cur_s); end
    to_neg(5);
    checks++; if (cur_s !== 16'd100 || act_s !== 1'b1) begin fails++; $display("FAIL latency_arrive got=%0d/%0b exp=100/1", cur_s, act_s); end
    to_neg(12);
    spike_in = 1'b0;
    to_neg(13);
    checks++; if (cur_s !== 16'd100) begin fails++; $display("FAIL oneshot_current got=%0d exp=100", cur_s); end
    checks++; if (ec_s !== 8'd1) begin fails++; $display("FAIL oneshot_count got=%0d exp=1", ec_s); end
  endtask

  task automatic test_decay();
    int exp_c;
    int k;
    do_reset();
    pulse_at(5, 8'd200);
    pulse_at(7, 8'd200);
    pulse_at(9, 8'd200);
    pulse_at(11, 8'd250);
    to_neg(11);
    checks++; if (cur_f !== 16'd800) begin fails++; $display("FAIL decay_load got=%0d exp=800", cur_f); end
    to_neg(12);
    checks++; if (cur_f !== 16'd700) begin fails++; $display("FAIL decay_t1 got=%0d exp=700", cur_f); end
    to_neg(16);
    checks++; if (cur_f !== 16'd613) begin fails++; $display("FAIL decay_t2 got=%0d exp=613", cur_f); end
    to_neg(20);
    checks++; if (cur_f !== 16'd537) begin fails++; $display("FAIL decay_t3 got=%0d exp=537", cur_f); end
    exp_c = 537;
    k = 20;
    for (int i = 0; i < 200 && exp_c != 0; i++) begin
      k += 4;
      exp_c = exp_c - (((exp_c >> 3) == 0) ? 1 : (exp_c >> 3));
      to_neg(k);
      checks++; if (cur_f !== exp_c[15:0] || act_f !== (exp_c != 0)) begin fails++; $display("FAIL decay_tail tick_cycle=%0d got=%0d/%0b exp=%0d/%0b", k, cur_f, act_f, exp_c, exp_c != 0); end
    end
    to_neg(k + 4);
    checks++; if (cur_f !== 16'd0 || act_f !== 1'b0) begin fails++; $display("FAIL decay_floor got=%0d/%0b exp=0/0", cur_f, act_f); end
  endtask

  task automatic test_saturation();
    int exp_c;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      pulse_at(5 + 3 * i, 8'd255);
      to_neg(5 + 3 * i);
      exp_c = (i + 1) * 255;
      if (exp_c > 65535) exp_c = 65535;
      checks++; if (cur_s !== exp_c[15:0]) begin fails++; $display("FAIL saturation_step n=%0d got=%0d exp=%0d", i + 1, cur_s, exp_c); end
    end
    checks++; if (cur_s !== 16'hFFFF || act_s !== 1'b1) begin fails++; $display("FAIL saturation_pin got=%h/%0b exp=ffff/1", cur_s, act_s); end
    checks++; if (ec_s !== 8'd44) begin fails++; $display("FAIL saturation_count got=%0d exp=44", ec_s); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse_at(5, 8'd64);
    to_neg(5);
    checks++; if (cur_f !== 16'd64) begin fails++; $display("FAIL simul_preload got=%0d exp=64", cur_f); end
    pulse_at(8, 8'd10);
    to_neg(8);
    checks++; if (cur_f !== 16'd66) begin fails++; $display("FAIL simul_tick_edge got=%0d exp=66", cur_f); end
    checks++; if (ec_f !== 8'd2) begin fails++; $display("FAIL simul_count got=%0d exp=2", ec_f); end
  endtask

  task automatic test_enable();
    do_reset();
    pulse_at(5, 8'd250);
    pulse_at(7, 8'd250);
    to_neg(8);
    checks++; if (cur_s !== 16'd500 || ec_s !== 8'd2) begin fails++; $display("FAIL enable_preload got=%0d/%0d exp=500/2", cur_s, ec_s); end
    en = 1'b0;
    to_neg(9);
    spike_in = 1'b1;
    to_neg(10);
    spike_in = 1'b0;
    to_neg(14);
    checks++; if (cur_s !== 16'd500 || ec_s !== 8'd2) begin fails++; $display("FAIL enable_gated got=%0d/%0d exp=500/2", cur_s, ec_s); end
    en = 1'b1;
    to_neg(20);
    checks++; if (cur_s !== 16'd500 || ec_s !== 8'd2) begin fails++; $display("FAIL enable_no_deferred got=%0d/%0d exp=500/2", cur_s, ec_s); end
    pulse_at(24, 8'd0);
    to_neg(24);
    checks++; if (cur_s !== 16'd500 || ec_s !== 8'd3) begin fails++; $display("FAIL zero_weight got=%0d/%0d exp=500/3", cur_s, ec_s); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_decay();
    test_saturation();
    test_simultaneous();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/izh_synapse.md
Name: izh_synapse

Overview:
- Current-based synapse on the input side of the Izhikevich neuron.
- Converts an incoming spike train, from a pin or from an upstream neuron's spike output, into the 16-bit synaptic current the neuron consumes.
- Each detected spike adds a programmable weight to a saturating accumulator.
- The accumulator decays exponentially on a prescaled tick, so the current output ties directly to the neuron's current input.

Parameters:
- DECAY_SHIFT, 3, decay per tick is current >> DECAY_SHIFT (range 1..15).
- DECAY_DIV, 4, clock cycles per decay tick (>=1); prescaler counter width is clog2(DECAY_DIV)+1.
- SYNC_STAGES, 2, synchroniser flops on spike_in (fixed at 2 in this revision).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- en, input, 1, synapse enable; when low, the accumulator and prescaler hold.
- spike_in, input, 1, presynaptic spike; may be asynchronous to clk; level or pulse.
- weight, input, 8, unsigned synaptic weight, sampled on the accepted spike edge.
- current, output, 16, unsigned synaptic current (registered).
- active, output, 1, high when current != 0 (registered with current).
- event_count, output, 8, count of accepted spike edges; wraps 255 -> 0.

Behaviour:
- Reset (async, reset_n low):
  - current = 0, active = 0, event_count = 0.
  - Prescaler = 0; synchroniser and edge-history flops = 0.
  - Release is synchronous to the next clk edge. Reset mid-accumulation discards all state immediately.
- Input path:
  - spike_in passes through flops s1 -> s2; s3 holds the previous s2.
  - edge = s2 & ~s3. Only rising edges count; a held-high spike_in yields exactly one event.
- Latency:
  - spike_in is first sampled high at clk edge N (into s1).
  - edge is true during cycle N+1 -> N+2.
  - current reflects the added weight after edge N+2 (3 edges total).
  - Pulses shorter than one clk period may be missed; the spec guarantees capture only for pulses >= 1 clk period.
- Prescaler:
  - Counts 0..DECAY_DIV-1 while en = 1.
  - tick = 1 in the cycle the count equals DECAY_DIV-1; the counter wraps to 0.
  - With DECAY_DIV = 1, tick = 1 every enabled cycle.
- Accumulator update, computed in one cycle when en = 1:
  - d = current >> DECAY_SHIFT. If tick and current != 0 and d == 0, then d = 1, so current always decays to exactly 0.
  - c1 = tick ? current - d : current. No underflow is possible.
  - If edge: sum = c1 + weight, computed 17 bits wide; current = (sum > 16'hFFFF) ? 16'hFFFF : sum[15:0].
  - Otherwise: current = c1.
  - Simultaneous tick and edge: decay first, then add, in the same cycle.
- active is updated with the same expression as current (next-state != 0), so it never lags current.
- event_count increments on every edge while en = 1; the 8-bit counter wraps.
- en = 0:
  - current, prescaler and event_count hold.
  - Synchroniser and edge-history flops keep running. A rising edge that arrives while en = 0 is dropped, not deferred.
- weight = 0: the event is still counted; current is unchanged apart from decay.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert reset_n = 0 mid-run with current = 16'h1234 -> current = 0, active = 0 and event_count = 0 within the same cycle (async); everything stays 0 for 5 cycles after release with spike_in = 0.
- Latency and one-shot:
  - Setup: DECAY_DIV = 1000 (no tick in window), weight = 8'd100; spike_in high from edge N and held for 10 cycles.
  - Response: current = 100 after edge N+2; no further change; event_count = 1.
- Decay:
  - Setup: DECAY_SHIFT = 3, DECAY_DIV = 4; load current = 800 with one spike of weight 200 repeated 4 times (no tick overlap), then spike_in = 0.
  - Response: subsequent tick values 700, 613, 537, ...
  - Tail: once current < 8, it decrements by 1 per tick to exactly 0; active drops to 0 with it.
- Saturation: weight = 255, 300 spikes spaced 4 cycles, DECAY_DIV = 1000 -> current rises in steps of 255 and pins at 16'hFFFF; never wraps; event_count = 300 mod 256 = 44.
- Simultaneous tick and edge:
  - Setup: current = 64, DECAY_SHIFT = 3, edge aligned to the tick cycle, weight = 10.
  - Response: current = 64 - 8 + 10 = 66.
- Enable gating: en = 0 with current = 500 and a spike edge during en = 0 -> current stays 500 and event_count is unchanged; after en = 1, no delayed event appears.
